// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single memory request channel
//
// Purpose: shares one memory port between an instruction-fetch requester and a
//          load/store requester, one outstanding transaction at a time. Data has
//          priority unless fetch has been passed over STARVE_MAX times in a row.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_req_i, i_addr_i, i_kill_i      fetch request, address, redirect/kill
//   i_gnt_o, i_rvalid_o, i_rdata_o   fetch grant and response
//   d_req_i, d_we_i, d_be_i,
//   d_addr_i, d_wdata_i              load/store request
//   d_gnt_o, d_rvalid_o, d_rdata_o   data grant and response
//   mem_req_o, mem_we_o, mem_be_o,
//   mem_addr_o, mem_wdata_o          shared memory request
//   mem_gnt_i, mem_rvalid_i,
//   mem_rdata_i                      memory accept and response

module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   input  logic              i_kill_i,
   output logic              i_gnt_o,
   output logic              i_rvalid_o,
   output logic [DATA_W-1:0] i_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [3:0]        d_be_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_be_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic            owner_q;     // 1 = fetch, 0 = data
   logic            hold_q;      // previous cycle requested but was not accepted
   logic            drop_q;      // in-flight fetch was killed; swallow its response
   logic [CW-1:0]   starve_q;

   logic            fetch_live;
   logic            sel_valid;
   logic            sel_fetch;
   logic            grant;
   logic            resp;

   // Owner selection, request/grant/response routing and next state.
   always_comb begin
      state_d    = state_q;
      sel_valid  = 1'b0;
      sel_fetch  = 1'b0;
      fetch_live = i_req_i & ~i_kill_i;

      // A stalled request keeps its owner so the memory sees stable fields,
      // unless that owner has dropped out; then choose afresh.
      if (hold_q && (owner_q ? fetch_live : d_req_i)) begin
         sel_valid = 1'b1;
         sel_fetch = owner_q;
      end else if (d_req_i && fetch_live) begin
         sel_valid = 1'b1;
         sel_fetch = (starve_q == STARVE_LIM);
      end else if (d_req_i) begin
         sel_valid = 1'b1;
      end else if (fetch_live) begin
         sel_valid = 1'b1;
         sel_fetch = 1'b1;
      end

      mem_req_o   = ~rst & (state_q == IDLE) & sel_valid;
      grant       = mem_req_o & mem_gnt_i;
      i_gnt_o     = grant & sel_fetch;
      d_gnt_o     = grant & ~sel_fetch;

      mem_we_o    = sel_fetch ? 1'b0 : d_we_i;
      mem_be_o    = sel_fetch ? 4'hF : d_be_i;
      mem_addr_o  = sel_fetch ? i_addr_i : d_addr_i;
      mem_wdata_o = sel_fetch ? '0 : d_wdata_i;

      resp        = ~rst & (state_q == BUSY) & mem_rvalid_i;
      d_rvalid_o  = resp & ~owner_q;
      i_rvalid_o  = resp & owner_q & ~drop_q & ~i_kill_i;
      i_rdata_o   = mem_rdata_i;
      d_rdata_o   = mem_rdata_i;

      case (state_q)
         IDLE:    if (grant) state_d = BUSY;
         BUSY:    if (mem_rvalid_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         hold_q   <= 1'b0;
         drop_q   <= 1'b0;
         starve_q <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= mem_req_o & ~mem_gnt_i;
         if (mem_req_o) owner_q <= sel_fetch;

         if (state_q == BUSY && mem_rvalid_i)
            drop_q <= 1'b0;
         else if (state_q == BUSY && owner_q && i_kill_i)
            drop_q <= 1'b1;

         if (!i_req_i || i_gnt_o)
            starve_q <= '0;
         else if (d_gnt_o && starve_q != STARVE_LIM)
            starve_q <= starve_q + CW'(1);
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a cycle reference model
//
// Purpose: directed scenarios plus randomized traffic, every output compared each
//          cycle against a transaction-level reference model.
// Ports:   none (top-level bench).

module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SMAX = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req_i, i_kill_i, d_req_i, d_we_i;
   logic [AW-1:0] i_addr_i, d_addr_i;
   logic [3:0]    d_be_i;
   logic [DW-1:0] d_wdata_i, mem_rdata_i;
   logic          mem_gnt_i, mem_rvalid_i;
   logic          i_gnt_o, i_rvalid_o, d_gnt_o, d_rvalid_o;
   logic [DW-1:0] i_rdata_o, d_rdata_o, mem_wdata_o;
   logic          mem_req_o, mem_we_o;
   logic [3:0]    mem_be_o;
   logic [AW-1:0] mem_addr_o;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_kill_i(i_kill_i),
      .i_gnt_o(i_gnt_o), .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i),
      .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: transaction in flight, its owner (0 data, 1 fetch),
   // pending stalled request, starvation count, kill-drop flag.
   bit m_busy, m_drop, m_hold;
   int m_owner, m_hold_owner, m_starve;
   int cur_own;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_busy = 0; m_drop = 0; m_hold = 0;
      m_owner = 0; m_hold_owner = -1; m_starve = 0;
   endtask

   // Settle after the input change, then compare every output with the model.
   task automatic chk_cycle();
      bit fl, e_req, e_ig, e_dg, e_ir, e_dr;
      int own;
      #1;
      own = -1; e_req = 0; e_ig = 0; e_dg = 0; e_ir = 0; e_dr = 0;
      if (!rst) begin
         if (!m_busy) begin
            fl = i_req_i && !i_kill_i;
            if (m_hold && ((m_hold_owner == 1 && fl) || (m_hold_owner == 0 && d_req_i)))
               own = m_hold_owner;
            else if (d_req_i && fl) own = (m_starve == SMAX) ? 1 : 0;
            else if (d_req_i) own = 0;
            else if (fl) own = 1;
            e_req = (own >= 0);
            e_ig  = (own == 1) && mem_gnt_i;
            e_dg  = (own == 0) && mem_gnt_i;
         end else begin
            e_dr = (m_owner == 0) && mem_rvalid_i;
            e_ir = (m_owner == 1) && mem_rvalid_i && !m_drop && !i_kill_i;
         end
      end
      cur_own = own;
      check("mem_req", mem_req_o, e_req);
      check("i_gnt", i_gnt_o, e_ig);
      check("d_gnt", d_gnt_o, e_dg);
      check("i_rvalid", i_rvalid_o, e_ir);
      check("d_rvalid", d_rvalid_o, e_dr);
      if (own == 0) begin
         check("mem_we_d", mem_we_o, d_we_i);
         check("mem_be_d", mem_be_o, d_be_i);
         check("mem_addr_d", mem_addr_o, d_addr_i);
         check("mem_wdata_d", mem_wdata_o, d_wdata_i);
      end else if (own == 1) begin
         check("mem_we_i", mem_we_o, 0);
         check("mem_be_i", mem_be_o, 4'hF);
         check("mem_addr_i", mem_addr_o, i_addr_i);
         check("mem_wdata_i", mem_wdata_o, 0);
      end
      if (e_ir) check("i_rdata", i_rdata_o, mem_rdata_i);
      if (e_dr) check("d_rdata", d_rdata_o, mem_rdata_i);
   endtask

   // Clock edge: advance the model with the inputs of the cycle just checked.
   task automatic adv();
      @(posedge clk);
      if (rst) model_reset();
      else begin
         if (!i_req_i) m_starve = 0;
         else if (!m_busy && mem_gnt_i && cur_own == 1) m_starve = 0;
         else if (!m_busy && mem_gnt_i && cur_own == 0 && m_starve < SMAX) m_starve++;
         if (!m_busy) begin
            if (cur_own >= 0 && mem_gnt_i) begin
               m_busy = 1; m_owner = cur_own; m_drop = 0; m_hold = 0;
            end else begin
               m_hold = (cur_own >= 0); m_hold_owner = cur_own;
            end
         end else if (mem_rvalid_i) begin
            m_busy = 0; m_drop = 0;
         end else if (m_owner == 1 && i_kill_i) m_drop = 1;
      end
      @(negedge clk);
   endtask

   task automatic quiet();
      rst = 0; i_req_i = 0; i_kill_i = 0; d_req_i = 0; d_we_i = 0;
      i_addr_i = 0; d_addr_i = 0; d_be_i = 0; d_wdata_i = 0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
   endtask

   task automatic do_reset();
      quiet(); rst = 1;
      i_req_i = 1; d_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
      chk_cycle(); adv();
      chk_cycle(); adv();
      quiet();
   endtask

   int fg, dcnt;

   initial begin
      model_reset();
      cur_own = -1;
      quiet();
      @(negedge clk);
      do_reset();

      // Single fetch, one-cycle memory.
      i_req_i = 1; i_addr_i = 32'h100; mem_gnt_i = 1;
      chk_cycle();
      check("t034_gnt", i_gnt_o, 1);
      check("t034_be", mem_be_o, 4'hF);
      check("t034_we", mem_we_o, 0);
      adv();
      i_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
      chk_cycle();
      check("t034_rvalid", i_rvalid_o, 1);
      check("t034_rdata", i_rdata_o, 32'hDEADBEEF);
      adv();
      quiet();

      // Fetch and store together: store first, fetch after its response.
      i_req_i = 1; i_addr_i = 32'h40; d_req_i = 1; d_we_i = 1; d_be_i = 4'h3;
      d_addr_i = 32'h200; d_wdata_i = 32'h1234; mem_gnt_i = 1;
      chk_cycle();
      check("t035_dgnt", d_gnt_o, 1);
      check("t035_we", mem_we_o, 1);
      check("t035_be", mem_be_o, 4'h3);
      adv();
      d_req_i = 0; mem_rvalid_i = 1;
      chk_cycle();
      check("t035_drvalid", d_rvalid_o, 1);
      adv();
      mem_rvalid_i = 0;
      chk_cycle();
      check("t035_ignt", i_gnt_o, 1);
      adv();
      mem_rvalid_i = 1; i_req_i = 0;
      chk_cycle(); adv();
      do_reset();

      // Starvation bound: data always pending alongside fetch.
      fg = 0; dcnt = 0;
      for (int i = 0; i < 24; i++) begin
         d_req_i = 1; i_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
         d_addr_i = i; i_addr_i = 32'h1000 + i;
         chk_cycle();
         if (i_gnt_o) begin
            fg++;
            check("t036_data_before_fetch", dcnt, SMAX);
            dcnt = 0;
         end else if (d_gnt_o) dcnt++;
         adv();
      end
      check("t036_fetch_grants", fg, 2);
      do_reset();

      // Kill during a fetch in flight; late response swallowed.
      i_req_i = 1; i_addr_i = 32'h300; mem_gnt_i = 1;
      chk_cycle(); check("t037_gnt", i_gnt_o, 1); adv();
      i_req_i = 0; i_kill_i = 1;
      chk_cycle(); adv();
      i_kill_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h55;
      chk_cycle(); check("t037_dropped", i_rvalid_o, 0); adv();
      mem_rvalid_i = 0; i_req_i = 1; i_addr_i = 32'h400;
      chk_cycle(); check("t037_regnt", i_gnt_o, 1); adv();
      i_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h66;
      chk_cycle(); check("t037_rvalid", i_rvalid_o, 1); adv();
      quiet();

      // Kill in IDLE suppresses the fetch request.
      i_req_i = 1; i_kill_i = 1; mem_gnt_i = 1;
      chk_cycle(); check("t029_req", mem_req_o, 0); check("t029_gnt", i_gnt_o, 0); adv();
      quiet();

      // Memory stalls three cycles; request held stable.
      d_req_i = 1; d_addr_i = 32'h500; d_be_i = 4'hC; d_wdata_i = 32'hA5A5; d_we_i = 1;
      for (int i = 0; i < 3; i++) begin
         chk_cycle();
         check("t038_req", mem_req_o, 1);
         check("t038_addr", mem_addr_o, 32'h500);
         check("t038_nognt", d_gnt_o, 0);
         adv();
      end
      mem_gnt_i = 1;
      chk_cycle(); check("t038_gnt", d_gnt_o, 1); adv();

      // Reset while busy, then a stray response.
      quiet(); rst = 1;
      chk_cycle(); adv();
      quiet(); mem_rvalid_i = 1; mem_rdata_i = 32'h77;
      chk_cycle();
      check("t039_drvalid", d_rvalid_o, 0);
      check("t039_irvalid", i_rvalid_o, 0);
      check("t039_req", mem_req_o, 0);
      adv();
      quiet();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rst          = ($urandom_range(0, 149) == 0);
         i_req_i      = ($urandom_range(0, 9) < 6);
         i_kill_i     = ($urandom_range(0, 9) == 0);
         d_req_i      = ($urandom_range(0, 9) < 6);
         d_we_i       = $urandom_range(0, 1);
         d_be_i       = 4'($urandom_range(0, 15));
         i_addr_i     = $urandom;
         d_addr_i     = $urandom;
         d_wdata_i    = $urandom;
         mem_gnt_i    = ($urandom_range(0, 9) < 7);
         mem_rvalid_i = ($urandom_range(0, 9) < 5);
         mem_rdata_i  = $urandom;
         chk_cycle();
         adv();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width (matches RISCV_ADDR_WIDTH).
REQ-002 SHALL have parameter DATA_W, default 32, memory word width (matches RISCV_WORD_WIDTH).
REQ-003 SHALL have parameter STARVE_MAX, default 4, max consecutive data grants while an instruction request waits.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 i_req_i  in  1  fetch read request.
REQ-007 i_addr_i  in  ADDR_W  fetch address.
REQ-008 i_kill_i  in  1  fetch redirect; discard any in-flight fetch response.
REQ-009 i_gnt_o  out  1  fetch request accepted this cycle.
REQ-010 i_rvalid_o / i_rdata_o  out  1 / DATA_W  fetch response.
REQ-011 d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i  in  1,1,4,ADDR_W,DATA_W  load/store request.
REQ-012 d_gnt_o  out  1  data request accepted this cycle.
REQ-013 d_rvalid_o / d_rdata_o  out  1 / DATA_W  data response (also pulses for stores).
REQ-014 mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1,1,4,ADDR_W,DATA_W  shared memory request.
REQ-015 mem_gnt_i  in  1  memory accepted request.
REQ-016 mem_rvalid_i / mem_rdata_i  in  1 / DATA_W  memory response.

Function
REQ-017 SHALL allow at most one outstanding memory transaction; states IDLE, BUSY (granted, awaiting mem_rvalid_i).
REQ-018 In IDLE, SHALL select an owner combinationally among asserted requests and drive mem_req_o=1 with that owner's fields; mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0 for fetch.
REQ-019 Priority SHALL be data over fetch, except when starve counter equals STARVE_MAX, then fetch wins.
REQ-020 Starve counter SHALL increment on each data grant while i_req_i=1, clear on fetch grant or when i_req_i=0, and saturate at STARVE_MAX.
REQ-021 Grant to a requester SHALL occur in the cycle mem_req_o=1 and mem_gnt_i=1; only the owner's *_gnt_o is asserted, equal to mem_gnt_i.
REQ-022 On grant, SHALL latch owner and move to BUSY; in BUSY mem_req_o=0 and both *_gnt_o=0.
REQ-023 Owner selection SHALL be held stable while mem_req_o=1 and mem_gnt_i=0, unless the owner drops its request (then re-evaluate next cycle).
REQ-024 In BUSY, mem_rvalid_i SHALL be routed to the latched owner's *_rvalid_o in the same cycle (zero added latency); rdata passed through unregistered.
REQ-025 SHALL return to IDLE on mem_rvalid_i; a new request MAY be issued that same cycle (back-to-back, one transaction per two cycles minimum with a one-cycle memory).
REQ-026 mem_rvalid_i in IDLE SHALL be ignored; no *_rvalid_o asserted.
REQ-027 i_kill_i=1 while BUSY with fetch owner SHALL set a drop flag; the matching response SHALL complete the transaction with i_rvalid_o=0; flag clears on that response.
REQ-028 i_kill_i coincident with mem_rvalid_i for fetch owner SHALL suppress i_rvalid_o that cycle.
REQ-029 i_kill_i in IDLE SHALL suppress i_gnt_o and mem_req_o for fetch that cycle.
REQ-030 i_kill_i SHALL never affect data transactions.

Reset
REQ-031 While rst=1: state=IDLE, owner=data, starve counter=0, drop flag=0.
REQ-032 While rst=1: mem_req_o, i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o SHALL be 0 regardless of inputs.
REQ-033 Reset asserted while BUSY SHALL abandon the transaction; a later mem_rvalid_i in IDLE is ignored per REQ-026.

Verification
REQ-034 Fetch only, addr 0x100, mem_gnt_i=1, mem_rvalid_i next cycle with 0xDEADBEEF -> i_gnt_o at T0, i_rvalid_o=1, i_rdata_o=0xDEADBEEF at T1, mem_we_o=0, mem_be_o=0xF.
REQ-035 Fetch and store (addr 0x200, be 0x3) same cycle -> d_gnt_o first, mem_we_o=1, mem_be_o=0x3; fetch granted after d_rvalid_o.
REQ-036 Continuous data requests plus fetch, STARVE_MAX=4 -> exactly 4 data grants, then fetch grant, counter back to 0.
REQ-037 Fetch granted, i_kill_i at BUSY cycle, response arrives -> i_rvalid_o stays 0, state IDLE, next fetch granted normally.
REQ-038 mem_gnt_i held 0 for 3 cycles with data request -> mem_req_o and fields stable, d_gnt_o only in 4th cycle.
REQ-039 rst pulsed while BUSY, then stray mem_rvalid_i -> all outputs 0, no rvalid to either port.
